// File: rtl/psram_qpi_model.sv
`default_nettype none
// psram_qpi_model: behavioural QSPI PSRAM supporting quad read (0xEB) and quad write (0x38).
// Define PSRAM_QPI_EN to enable the QPI command mode (0x35 enter / 0xF5 exit).
module psram_qpi_model #(
   parameter int ADDR_W       = 22,
   parameter int DUMMY_CYCLES = 6
) (
   input  logic       sck,
   input  logic       rst_n,
   input  logic       ce_n,
   inout  wire  [3:0] dio,
   output logic       qpi
);

   typedef enum logic [2:0] {
      S_CMD    = 3'd0,
      S_ADDR   = 3'd1,
      S_DUMMY  = 3'd2,
      S_READ   = 3'd3,
      S_WRITE  = 3'd4,
      S_IGNORE = 3'd5
   } state_t;

   localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CYCLES - 1);

   state_t            state, state_nx;
   logic [3:0]        cnt, cnt_nx;
   logic [7:0]        cmd, cmd_nx;
   logic [ADDR_W-1:0] addr, addr_nx;
   logic              qpi_cmd;
   logic              txn_rst_n;
   logic              drive;
   logic [7:0]        rd_byte;
   logic [7:0]        mem [2**ADDR_W];

   // Transaction state is cleared by either device reset or a deselect.
   assign txn_rst_n = rst_n & ~ce_n;

`ifdef PSRAM_QPI_EN
   logic qpi_set, qpi_clr;

   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n) begin
         qpi <= 1'b0;
      end else if (!ce_n) begin
         if (qpi_set)
            qpi <= 1'b1;
         else if (qpi_clr)
            qpi <= 1'b0;
      end
   end

   assign qpi_cmd = qpi;
`else
   assign qpi     = 1'b0;
   assign qpi_cmd = 1'b0;
`endif

   always_ff @(posedge sck or negedge txn_rst_n) begin
      if (!txn_rst_n) begin
         state <= S_CMD;
         cnt   <= 4'd0;
         cmd   <= 8'h00;
         addr  <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         cmd   <= cmd_nx;
         addr  <= addr_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + 4'd1;
      cmd_nx   = cmd;
      addr_nx  = addr;
`ifdef PSRAM_QPI_EN
      qpi_set  = 1'b0;
      qpi_clr  = 1'b0;
`endif
      case (state)
         S_CMD: begin
            cmd_nx = qpi_cmd ? {cmd[3:0], dio} : {cmd[6:0], dio[0]};
            if (cnt == (qpi_cmd ? 4'd1 : 4'd7)) begin
               cnt_nx = 4'd0;
               case (cmd_nx)
                  8'hEB, 8'h38: state_nx = S_ADDR;
`ifdef PSRAM_QPI_EN
                  8'h35: begin
                     qpi_set  = 1'b1;
                     state_nx = S_IGNORE;
                  end
                  8'hF5: begin
                     qpi_clr  = 1'b1;
                     state_nx = S_IGNORE;
                  end
`endif
                  default: state_nx = S_IGNORE;
               endcase
            end
         end
         S_ADDR: begin
            // Shifting all six nibbles leaves only the low ADDR_W address bits.
            addr_nx = {addr[ADDR_W-5:0], dio};
            if (cnt == 4'd5) begin
               cnt_nx   = 4'd0;
               state_nx = (cmd == 8'hEB) ? S_DUMMY : S_WRITE;
            end
         end
         S_DUMMY: begin
            if (cnt == DUMMY_LAST) begin
               cnt_nx   = 4'd0;
               state_nx = S_READ;
            end
         end
         S_READ, S_WRITE: begin
            cnt_nx = {3'b000, ~cnt[0]};
            if (cnt[0])
               addr_nx = addr + 1'b1;
         end
         S_IGNORE: cnt_nx = cnt;
         default: begin
            cnt_nx   = cnt;
            state_nx = S_IGNORE;
         end
      endcase
   end

   // Each nibble is committed on the edge that samples it, so a short write keeps its high nibble.
   always_ff @(posedge sck) begin
      if (txn_rst_n && state == S_WRITE) begin
         if (cnt[0])
            mem[addr][3:0] <= dio;
         else
            mem[addr][7:4] <= dio;
      end
   end

   assign rd_byte = mem[addr];
   assign drive   = txn_rst_n && (state == S_READ);
   assign dio     = drive ? (cnt[0] ? rd_byte[3:0] : rd_byte[7:4]) : 4'bzzzz;

endmodule
`default_nettype wire
